uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter; next generation of the team's fixed 8N1 transmitter.
- Adds:
  - configurable data width, stop bits, optional even/odd parity and per-bit oversampling;
  - asynchronous reset;
  - a ready/start handshake.
- Sits between the host data source and the serial pin.
- Consumes a one-cycle `tick` strobe from the external baud generator.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal 5..9.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- OVERSAMPLE, 16, tick strobes per serial bit; legal 1..64.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  baud strobe, one clk wide, from external baud generator.
- tx_start  input  1  request to send data_in; sampled only when tx_ready = 1.
- data_in  input  DATA_BITS  payload; captured on the accepting edge.
- tx_ready  output  1  high only in IDLE; transmitter can accept a frame.
- txd  output  1  serial line; registered; idle level 1.
- tx_done  output  1  one-clk pulse on frame completion.

Behaviour:
- Reset, asynchronous, any state, effective immediately:
  - state = IDLE, txd = 1, tx_ready = 1, tx_done = 0;
  - tick counter, bit counter and shift register cleared.
- Accept: the rising edge with state IDLE and tx_start = 1. On that edge:
  - data_in goes into the shift register;
  - parity bit is computed (XOR-reduce of data_in, inverted if PARITY_ODD);
  - state goes to START, txd goes to 0, tx_ready goes to 0.
  - Latency from tx_start to txd falling: one edge.
- tx_start outside IDLE is ignored. data_in changes after acceptance have no effect.
- Tick counter: counts tick strobes from 0 to OVERSAMPLE-1. A bit period ends on the tick that finds the counter at OVERSAMPLE-1; the counter then wraps to 0. Clock cycles without tick do not advance any counter.
- START: txd = 0 for one bit period, then go to DATA with txd = shift[0].
- DATA:
  - Each bit-period end shifts the register right one bit and increments the bit counter.
  - After bit DATA_BITS-1 ends: go to PARITY if PARITY_EN, else STOP.
  - Bits are sent LSB first.
- PARITY: txd = parity bit for one bit period, then go to STOP.
- STOP:
  - txd = 1 for STOP_BITS bit periods; the second stop bit is counted by the bit counter.
  - At the final period end: state goes to IDLE, tx_done = 1 for exactly one clk, tx_ready goes to 1 on the same edge.
- Back-to-back: tx_start held high is accepted on the first edge in IDLE, i.e. the edge after tx_done. No extra idle bit is inserted beyond the stop bit(s).
- Frame length in ticks: OVERSAMPLE × (1 + DATA_BITS + PARITY_EN + STOP_BITS).
- tick arriving on the accept edge is not counted toward START.
- Counter widths: tick counter $clog2(OVERSAMPLE) with a minimum of 1; bit counter $clog2(DATA_BITS+1). No overflow is reachable.
- txd is driven only from a flop: no combinational path from inputs to txd.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum: IDLE, START, DATA, PARITY, STOP (2'b/3'b encoding);
  - constants UART_IDLE_LEVEL = 1'b1 and UART_START_LEVEL = 1'b0;
  - function uart_parity(data, odd).
- Natural sub-module: uart_bit_timer. It holds the tick counter and outputs `bit_end` (tick & cnt == OVERSAMPLE-1), with synchronous clear on accept.
- The baud generator stays external.

Test Plan:
- Basic 8N1 frame: OVERSAMPLE=16, tick every clk, data_in=8'hA5, tx_start pulsed in IDLE.
  - txd levels per 16-tick period: 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses exactly 160 clks after acceptance; tx_ready is low throughout the frame.
- Even parity: PARITY_EN=1, PARITY_ODD=0, data 8'h07.
  - Parity bit = 1; frame is 11 bits / 176 ticks.
  - Repeat with PARITY_ODD=1: parity bit = 0.
- Narrow payload, two stop bits: DATA_BITS=7, STOP_BITS=2, tick every 4 clks, data 7'h55.
  - Data bits 1,0,1,0,1,0,1, then two stop bits of 1.
  - tx_done after 10×16 ticks = 640 clks.
- Busy and back-to-back: tx_start toggled with data_in=8'hFF mid-frame of 8'h3C.
  - Frame content is unchanged.
  - tx_start held high afterwards: second frame's start bit begins on the edge after tx_done.
- Async reset mid-operation: assert rst during DATA bit 3, between clk edges.
  - txd = 1, tx_ready = 1, tx_done = 0 immediately.
  - After release, a new frame 8'h81 transmits correctly from the start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, line levels and parity helper for the UART transmitter
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

   // Payloads narrower than 9 bits are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic uart_parity(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - host-side handshake and serial line bundle for the UART transmitter
interface uart_tx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic                 tick;
   logic                 tx_start;
   logic [DATA_BITS-1:0] data_in;
   logic                 tx_ready;
   logic                 txd;
   logic                 tx_done;

   modport master (
      output tick, tx_start, data_in,
      input  tx_ready, txd, tx_done
   );

   modport slave (
      input  tick, tx_start, data_in,
      output tx_ready, txd, tx_done
   );
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - counts baud ticks and flags the tick that ends each serial bit
module uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic clr,
   output logic bit_end
);
   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] cnt;

   assign bit_end = tick && (cnt == CNT_MAX);

   // Tick counter; clear wins over tick so a tick on the accept edge is not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with ready/start handshake
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int OVERSAMPLE = 16
) (
   input  logic         clk,
   input  logic         rst,
   uart_tx_cfg_if.slave bus
);
   localparam int BCW = $clog2(DATA_BITS + 1);

   tx_state_t            state;
   logic [DATA_BITS-1:0] shift;
   logic [BCW-1:0]       bit_cnt;
   logic                 par_bit;
   logic                 txd_q;
   logic                 ready_q;
   logic                 done_q;
   logic                 bit_end;
   logic [8:0]           data_ext;

   assign bus.txd      = txd_q;
   assign bus.tx_ready = ready_q;
   assign bus.tx_done  = done_q;

   // Zero-extend the payload so the shared parity helper sees a fixed width.
   always_comb begin
      data_ext                = '0;
      data_ext[DATA_BITS-1:0] = bus.data_in;
   end

   // Timer is held clear while idle, so every frame starts from a fresh bit period.
   uart_bit_timer #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_bit_timer (
      .clk    (clk),
      .rst    (rst),
      .tick   (bus.tick),
      .clr    (state == IDLE),
      .bit_end(bit_end)
   );

   // Frame sequencer; txd, tx_ready and tx_done are all registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         txd_q   <= UART_IDLE_LEVEL;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         shift   <= '0;
         bit_cnt <= '0;
         par_bit <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.tx_start) begin
                  shift   <= bus.data_in;
                  par_bit <= uart_parity(data_ext, PARITY_ODD != 0);
                  bit_cnt <= '0;
                  txd_q   <= UART_START_LEVEL;
                  ready_q <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  txd_q <= shift[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift <= shift >> 1;
                  if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        txd_q <= par_bit;
                        state <= PARITY;
                     end else begin
                        txd_q <= UART_IDLE_LEVEL;
                        state <= STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     txd_q   <= shift[1];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  txd_q <= UART_IDLE_LEVEL;
                  state <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (STOP_BITS == 2 && bit_cnt == '0) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end else begin
                     bit_cnt <= '0;
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               txd_q   <= UART_IDLE_LEVEL;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg across four configurations
module tb_uart_tx_cfg;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [3:0] start_v;
   logic [8:0] data_v;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int OS = 16;

   // per-instance configuration: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 7N2
   int cfg_nbits [4] = '{8, 8, 8, 7};
   int cfg_par   [4] = '{0, 1, 1, 0};
   int cfg_odd   [4] = '{0, 0, 1, 0};
   int cfg_stop  [4] = '{1, 1, 1, 2};

   always #5 clk = ~clk;

   uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
   uart_tx_cfg_if #(.DATA_BITS(8)) if_b ();
   uart_tx_cfg_if #(.DATA_BITS(8)) if_c ();
   uart_tx_cfg_if #(.DATA_BITS(7)) if_d ();

   assign if_a.tick = tick;
   assign if_b.tick = tick;
   assign if_c.tick = tick;
   assign if_d.tick = tick;
   assign if_a.tx_start = start_v[0];
   assign if_b.tx_start = start_v[1];
   assign if_c.tx_start = start_v[2];
   assign if_d.tx_start = start_v[3];
   assign if_a.data_in = data_v[7:0];
   assign if_b.data_in = data_v[7:0];
   assign if_c.data_in = data_v[7:0];
   assign if_d.data_in = data_v[6:0];

   uart_tx_cfg #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(OS))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));
   uart_tx_cfg #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLE(OS))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));
   uart_tx_cfg #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1), .OVERSAMPLE(OS))
      dut_c (.clk(clk), .rst(rst), .bus(if_c));
   uart_tx_cfg #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(OS))
      dut_d (.clk(clk), .rst(rst), .bus(if_d));

   wire [3:0] txd_all  = {if_d.txd, if_c.txd, if_b.txd, if_a.txd};
   wire [3:0] rdy_all  = {if_d.tx_ready, if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};
   wire [3:0] done_all = {if_d.tx_done, if_c.tx_done, if_b.tx_done, if_a.tx_done};

   typedef struct {
      int          k;
      logic [8:0]  d;
      int          period;
      logic [15:0] bits;
      int          clks;
      bit          busy;
      bit          hold;
   } vec_t;

   vec_t vecs[6];

   task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: txd/ready/done got %b required %b at %0t", name, act, req, $time);
      end
   endtask

   function automatic int frame_len(input int k);
      return 1 + cfg_nbits[k] + cfg_par[k] + cfg_stop[k];
   endfunction

   // Reference frame: bit i is the line level during the i-th bit period.
   function automatic logic [15:0] build_frame(input logic [8:0] d, input int k);
      logic [15:0] f;
      int ones;
      f    = '1;
      f[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < cfg_nbits[k]; i++) begin
         f[1 + i] = d[i];
         if (d[i]) ones++;
      end
      if (cfg_par[k] != 0)
         f[1 + cfg_nbits[k]] = ((ones % 2) == 1) ? (cfg_odd[k] == 0) : (cfg_odd[k] != 0);
      return f;
   endfunction

   // Starts at a negedge with the selected DUT idle; ends at the negedge where tx_done is seen.
   task automatic run_frame(input int k, input logic [8:0] d, input logic [15:0] bits,
                            input int period, input int exp_clks, input bit busy,
                            input bit hold, input int abort_t, input string name);
      int len;
      int t_cnt;
      int clks;
      int ph;
      int limit;
      bit fin;
      logic [2:0] req;
      len   = frame_len(k);
      t_cnt = 0;
      clks  = 0;
      ph    = 0;
      fin   = 1'b0;
      limit = OS * len * ((period > 0) ? period : 1) * 8 + 64;
      n_tests++;
      if ({txd_all[k], rdy_all[k]} !== 2'b11) begin
         n_fail++;
         $display("FAIL %s_idle: txd/ready got %b required 11", name, {txd_all[k], rdy_all[k]});
      end
      data_v     = d;
      start_v    = 4'b0;
      start_v[k] = 1'b1;
      tick       = (period > 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk);
      while (!fin) begin
         @(negedge clk);
         if (t_cnt == OS * len) begin
            req = 3'b111;
            fin = 1'b1;
         end else begin
            req = {bits[t_cnt / OS], 2'b00};
         end
         check3(name, {txd_all[k], rdy_all[k], done_all[k]}, req);
         if (fin) begin
            if (exp_clks > 0) begin
               n_tests++;
               if (clks != exp_clks) begin
                  n_fail++;
                  $display("FAIL %s_latency: got %0d clks required %0d", name, clks, exp_clks);
               end
            end
            start_v    = 4'b0;
            start_v[k] = hold;
            tick       = 1'b0;
         end else if (abort_t >= 0 && t_cnt >= abort_t) begin
            #2;
            rst = 1'b1;
            #1;
            check3({name, "_async_rst"}, {txd_all[k], rdy_all[k], done_all[k]}, 3'b110);
            start_v = 4'b0;
            tick    = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            fin = 1'b1;
         end else begin
            start_v    = 4'b0;
            start_v[k] = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            data_v     = busy ? 9'h1FF : 9'($urandom);
            ph++;
            tick = (period > 0) ? ((ph % period) == 0) : 1'($urandom_range(0, 1));
            if (tick) t_cnt++;
            clks++;
            if (clks > limit) begin
               n_tests++;
               n_fail++;
               $display("FAIL %s_timeout: got no tx_done after %0d clks required %0d ticks", name, clks, OS * len);
               fin = 1'b1;
            end
         end
      end
   endtask

   initial begin
      logic [8:0] rd;
      int         rk;
      rst     = 1'b1;
      tick    = 1'b0;
      start_v = 4'b0;
      data_v  = '0;

      vecs[0] = '{0, 9'h0A5, 1, 16'h034A, 160, 1'b0, 1'b0};
      vecs[1] = '{1, 9'h007, 1, 16'h060E, 176, 1'b0, 1'b0};
      vecs[2] = '{2, 9'h007, 1, 16'h040E, 176, 1'b0, 1'b0};
      vecs[3] = '{3, 9'h055, 4, 16'h03AA, 640, 1'b0, 1'b0};
      vecs[4] = '{0, 9'h03C, 1, 16'h0278, 160, 1'b1, 1'b1};
      vecs[5] = '{0, 9'h0C3, 1, 16'h0386, 160, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++)
         check3($sformatf("reset_state_%0d", k), {txd_all[k], rdy_all[k], done_all[k]}, 3'b110);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++)
         check3($sformatf("post_reset_idle_%0d", k), {txd_all[k], rdy_all[k], done_all[k]}, 3'b110);

      for (int i = 0; i < 6; i++)
         run_frame(vecs[i].k, vecs[i].d, vecs[i].bits, vecs[i].period, vecs[i].clks,
                   vecs[i].busy, vecs[i].hold, -1, $sformatf("vec%0d", i));

      run_frame(0, 9'h03C, build_frame(9'h03C, 0), 1, 0, 1'b0, 1'b0, 70, "reset_mid");
      run_frame(0, 9'h081, 16'h0302, 1, 160, 1'b0, 1'b0, -1, "after_reset");

      for (int i = 0; i < 8; i++) begin
         rk = $urandom_range(0, 3);
         rd = 9'($urandom);
         run_frame(rk, rd, build_frame(rd, rk), 0, 0, 1'($urandom_range(0, 1)), 1'b0, -1,
                   $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
